// File: rtl/rgb888_to_ycbcr422.sv
// RGB888 to BT.601 limited-range YCbCr 4:2:2 for the ADV7513 transmit path.
// Five-stage pipeline: products, sum/round/shift, offset/clamp, chroma pairing,
// output register. DE/HSYNC/VSYNC ride a matching delay line so the outputs
// drive the HDMI TX data and sync pins directly.
module rgb888_to_ycbcr422 #(
   parameter int LATENCY    = 5,     // fixed; the datapath is built for 5 only
   parameter bit CHROMA_AVG = 1'b1   // 1 = average chroma over pixel pairs, 0 = decimate
) (
   input  logic       pixel_clk,
   input  logic       reset_n,
   input  logic       in_de,
   input  logic       in_hsync,
   input  logic       in_vsync,
   input  logic [7:0] in_r,
   input  logic [7:0] in_g,
   input  logic [7:0] in_b,
   output logic       out_de,
   output logic       out_hsync,
   output logic       out_vsync,
   output logic [7:0] out_y,
   output logic [7:0] out_cbcr
);

   // timing delay lines; index 0 is aligned with S1, index 4 with S5
   logic [LATENCY-1:0] de_q;
   logic [LATENCY-1:0] hs_q;
   logic [LATENCY-1:0] vs_q;

   // S1 products, kept as unsigned magnitudes; signs are applied in S2
   logic [15:0] p_yr_q, p_yg_q, p_yb_q;
   logic [15:0] p_ur_q, p_ug_q, p_ub_q;
   logic [15:0] p_vr_q, p_vg_q, p_vb_q;

   // S2 rounded/shifted components, before offset
   logic signed [19:0] y_sum, cb_sum, cr_sum;
   logic signed [11:0] y2_d, cb2_d, cr2_d;
   logic signed [11:0] y2_q, cb2_q, cr2_q;

   // S3 offset and clamped components
   logic signed [12:0] y_off, cb_off, cr_off;
   logic [7:0]         y3_d, cb3_d, cr3_d;
   logic [7:0]         y3_q, cb3_q, cr3_q;

   // S4 pixel under chroma pairing
   logic [7:0] y4_q, cb4_q, cr4_q;
   logic       phase_d, phase_q;
   logic [7:0] cr_prev_q;
   logic [8:0] cb_pair_sum, cr_pair_sum;
   logic [7:0] cbcr_sel;

   // S5 output register
   logic [7:0] out_y_d, out_cbcr_d;
   logic [7:0] out_y_q, out_cbcr_q;

   function automatic logic [7:0] clamp8(input logic signed [12:0] v,
                                         input logic signed [12:0] lo,
                                         input logic signed [12:0] hi);
      logic [7:0] r;
      if (v < lo) begin
         r = lo[7:0];
      end else if (v > hi) begin
         r = hi[7:0];
      end else begin
         r = v[7:0];
      end
      return r;
   endfunction

   // sync and DE pure delays; syncs idle high, DE idles low
   always_ff @(posedge pixel_clk or negedge reset_n) begin
      if (!reset_n) begin
         de_q <= '0;
         hs_q <= '1;
         vs_q <= '1;
      end else begin
         de_q <= {de_q[LATENCY-2:0], in_de};
         hs_q <= {hs_q[LATENCY-2:0], in_hsync};
         vs_q <= {vs_q[LATENCY-2:0], in_vsync};
      end
   end

   // S1: coefficient products
   always_ff @(posedge pixel_clk or negedge reset_n) begin
      if (!reset_n) begin
         p_yr_q <= '0;
         p_yg_q <= '0;
         p_yb_q <= '0;
         p_ur_q <= '0;
         p_ug_q <= '0;
         p_ub_q <= '0;
         p_vr_q <= '0;
         p_vg_q <= '0;
         p_vb_q <= '0;
      end else begin
         p_yr_q <= 16'd66  * 16'(in_r);
         p_yg_q <= 16'd129 * 16'(in_g);
         p_yb_q <= 16'd25  * 16'(in_b);
         p_ur_q <= 16'd38  * 16'(in_r);
         p_ug_q <= 16'd74  * 16'(in_g);
         p_ub_q <= 16'd112 * 16'(in_b);
         p_vr_q <= 16'd112 * 16'(in_r);
         p_vg_q <= 16'd94  * 16'(in_g);
         p_vb_q <= 16'd18  * 16'(in_b);
      end
   end

   // S2 combinational: signed sum, +128 rounding, floor shift by 8
   always_comb begin
      y_sum  = $signed({4'd0, p_yr_q}) + $signed({4'd0, p_yg_q})
             + $signed({4'd0, p_yb_q}) + 20'sd128;
      cb_sum = $signed({4'd0, p_ub_q}) - $signed({4'd0, p_ur_q})
             - $signed({4'd0, p_ug_q}) + 20'sd128;
      cr_sum = $signed({4'd0, p_vr_q}) - $signed({4'd0, p_vg_q})
             - $signed({4'd0, p_vb_q}) + 20'sd128;
      y2_d   = y_sum[19:8];
      cb2_d  = cb_sum[19:8];
      cr2_d  = cr_sum[19:8];
   end

   // S2 register
   always_ff @(posedge pixel_clk or negedge reset_n) begin
      if (!reset_n) begin
         y2_q  <= '0;
         cb2_q <= '0;
         cr2_q <= '0;
      end else begin
         y2_q  <= y2_d;
         cb2_q <= cb2_d;
         cr2_q <= cr2_d;
      end
   end

   // S3 combinational: add offsets and clamp to the limited range
   always_comb begin
      y_off  = $signed({y2_q[11], y2_q})   + 13'sd16;
      cb_off = $signed({cb2_q[11], cb2_q}) + 13'sd128;
      cr_off = $signed({cr2_q[11], cr2_q}) + 13'sd128;
      y3_d   = clamp8(y_off,  13'sd16, 13'sd235);
      cb3_d  = clamp8(cb_off, 13'sd16, 13'sd240);
      cr3_d  = clamp8(cr_off, 13'sd16, 13'sd240);
   end

   // S3 register
   always_ff @(posedge pixel_clk or negedge reset_n) begin
      if (!reset_n) begin
         y3_q  <= 8'd16;
         cb3_q <= 8'd128;
         cr3_q <= 8'd128;
      end else begin
         y3_q  <= y3_d;
         cb3_q <= cb3_d;
         cr3_q <= cr3_d;
      end
   end

   // phase of the pixel entering S4: odd only when it directly follows an even
   // valid pixel, so every DE run (including after a 1-cycle gap) starts on Cb
   always_comb begin
      phase_d = 1'b0;
      if (de_q[2] && de_q[3]) begin
         phase_d = ~phase_q;
      end
   end

   // S4 register, phase and held Cr of the previous (even) pixel
   always_ff @(posedge pixel_clk or negedge reset_n) begin
      if (!reset_n) begin
         y4_q      <= 8'd16;
         cb4_q     <= 8'd128;
         cr4_q     <= 8'd128;
         phase_q   <= 1'b0;
         cr_prev_q <= 8'd128;
      end else begin
         y4_q    <= y3_q;
         cb4_q   <= cb3_q;
         cr4_q   <= cr3_q;
         phase_q <= phase_d;
         if (de_q[3]) begin
            cr_prev_q <= cr4_q;
         end
      end
   end

   // S4 chroma pairing; an even pixel averages with its partner in S3 only
   // when that partner is valid, which keeps pairing inside one DE run
   always_comb begin
      cb_pair_sum = {1'b0, cb4_q} + {1'b0, cb3_q} + 9'd1;
      cr_pair_sum = {1'b0, cr_prev_q} + {1'b0, cr4_q} + 9'd1;
      cbcr_sel    = cb4_q;
      if (CHROMA_AVG) begin
         if (phase_q) begin
            cbcr_sel = cr_pair_sum[8:1];
         end else if (de_q[2]) begin
            cbcr_sel = cb_pair_sum[8:1];
         end
      end else if (phase_q) begin
         cbcr_sel = cr4_q;
      end
      out_y_d    = 8'd16;
      out_cbcr_d = 8'd128;
      if (de_q[3]) begin
         out_y_d    = y4_q;
         out_cbcr_d = cbcr_sel;
      end
   end

   // S5 output register; blanking forces black in limited range
   always_ff @(posedge pixel_clk or negedge reset_n) begin
      if (!reset_n) begin
         out_y_q    <= 8'd16;
         out_cbcr_q <= 8'd128;
      end else begin
         out_y_q    <= out_y_d;
         out_cbcr_q <= out_cbcr_d;
      end
   end

   assign out_de    = de_q[LATENCY-1];
   assign out_hsync = hs_q[LATENCY-1];
   assign out_vsync = vs_q[LATENCY-1];
   assign out_y     = out_y_q;
   assign out_cbcr  = out_cbcr_q;

endmodule

// File: tb/tb_rgb888_to_ycbcr422.sv
// Scoreboard bench for rgb888_to_ycbcr422: one instance averaging chroma, one
// decimating, both fed the same stimulus. Expected outputs are queued when a
// pixel is driven and popped when that pixel leaves the pipeline.
module tb_rgb888_to_ycbcr422;

   logic       pixel_clk = 1'b0;
   logic       reset_n   = 1'b1;
   logic       in_de     = 1'b0;
   logic       in_hsync  = 1'b1;
   logic       in_vsync  = 1'b1;
   logic [7:0] in_r = '0, in_g = '0, in_b = '0;

   logic       a_de, a_hs, a_vs;
   logic [7:0] a_y, a_cbcr;
   logic       d_de, d_hs, d_vs;
   logic [7:0] d_y, d_cbcr;

   always #5 pixel_clk = ~pixel_clk;

   rgb888_to_ycbcr422 #(.LATENCY(5), .CHROMA_AVG(1'b1)) dut_avg (
      .pixel_clk (pixel_clk),
      .reset_n   (reset_n),
      .in_de     (in_de),
      .in_hsync  (in_hsync),
      .in_vsync  (in_vsync),
      .in_r      (in_r),
      .in_g      (in_g),
      .in_b      (in_b),
      .out_de    (a_de),
      .out_hsync (a_hs),
      .out_vsync (a_vs),
      .out_y     (a_y),
      .out_cbcr  (a_cbcr)
   );

   rgb888_to_ycbcr422 #(.LATENCY(5), .CHROMA_AVG(1'b0)) dut_dec (
      .pixel_clk (pixel_clk),
      .reset_n   (reset_n),
      .in_de     (in_de),
      .in_hsync  (in_hsync),
      .in_vsync  (in_vsync),
      .in_r      (in_r),
      .in_g      (in_g),
      .in_b      (in_b),
      .out_de    (d_de),
      .out_hsync (d_hs),
      .out_vsync (d_vs),
      .out_y     (d_y),
      .out_cbcr  (d_cbcr)
   );

   typedef struct {
      logic       de;
      logic       hs;
      logic       vs;
      logic [7:0] y;
      logic [7:0] cbcr_dec;
      logic [7:0] cbcr_avg;
   } exp_t;

   exp_t exp_q[$];
   int   err_cnt = 0;
   int   chk_cnt = 0;

   // reference-model run state
   bit   m_de    = 1'b0;
   bit   m_phase = 1'b0;
   int   m_cb    = 0;
   int   m_cr    = 0;

   // active-pixel captures for the directed tests
   int   cap_y[$], cap_avg[$], cap_dec[$];
   int   ey[$], ea[$], ed[$];

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   function automatic int conv(input int kr, input int kg, input int kb, input int off,
                               input int lo, input int hi, input int r, input int g, input int b);
      int s;
      s = kr * r + kg * g + kb * b + 128;
      s = (s >>> 8) + off;
      if (s < lo) s = lo;
      if (s > hi) s = hi;
      return s;
   endfunction

   task automatic model_push(input bit de, input bit hs, input bit vs,
                             input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
      exp_t e, last;
      int   y, cb, cr;
      bit   ph;
      e.de = de;
      e.hs = hs;
      e.vs = vs;
      cb   = 0;
      cr   = 0;
      ph   = 1'b0;
      if (de) begin
         y  = conv(66, 129, 25, 16, 16, 235, int'(r), int'(g), int'(b));
         cb = conv(-38, -74, 112, 128, 16, 240, int'(r), int'(g), int'(b));
         cr = conv(112, -94, -18, 128, 16, 240, int'(r), int'(g), int'(b));
         ph = m_de ? ~m_phase : 1'b0;
         e.y        = 8'(y);
         e.cbcr_dec = ph ? 8'(cr) : 8'(cb);
         e.cbcr_avg = ph ? 8'((m_cr + cr + 1) >> 1) : 8'(cb);
         if (ph) begin
            // the previous even pixel now has a partner
            last          = exp_q.pop_back();
            last.cbcr_avg = 8'((m_cb + cb + 1) >> 1);
            exp_q.push_back(last);
         end
      end else begin
         e.y        = 8'd16;
         e.cbcr_dec = 8'd128;
         e.cbcr_avg = 8'd128;
      end
      m_de    = de;
      m_phase = ph;
      m_cb    = cb;
      m_cr    = cr;
      exp_q.push_back(e);
   endtask

   // pipeline contents right after reset release: four cycles of reset values
   task automatic model_reset();
      exp_t e;
      exp_q.delete();
      e.de = 1'b0; e.hs = 1'b1; e.vs = 1'b1;
      e.y = 8'd16; e.cbcr_dec = 8'd128; e.cbcr_avg = 8'd128;
      for (int i = 0; i < 4; i++) exp_q.push_back(e);
      m_de    = 1'b0;
      m_phase = 1'b0;
   endtask

   task automatic compare_out();
      exp_t e;
      if (exp_q.size() == 0) begin
         check_val("sb_underflow", 32'd0, 32'd1);
         return;
      end
      e = exp_q.pop_front();
      check_val("avg_de",   a_de,   e.de);
      check_val("avg_hs",   a_hs,   e.hs);
      check_val("avg_vs",   a_vs,   e.vs);
      check_val("avg_y",    a_y,    e.y);
      check_val("avg_cbcr", a_cbcr, e.cbcr_avg);
      check_val("dec_de",   d_de,   e.de);
      check_val("dec_hs",   d_hs,   e.hs);
      check_val("dec_vs",   d_vs,   e.vs);
      check_val("dec_y",    d_y,    e.y);
      check_val("dec_cbcr", d_cbcr, e.cbcr_dec);
      if (a_de === 1'b1) begin
         cap_y.push_back(int'(a_y));
         cap_avg.push_back(int'(a_cbcr));
      end
      if (d_de === 1'b1) cap_dec.push_back(int'(d_cbcr));
   endtask

   task automatic drive_px(input bit de, input bit hs, input bit vs,
                           input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
      in_de    = de;
      in_hsync = hs;
      in_vsync = vs;
      in_r     = r;
      in_g     = g;
      in_b     = b;
      model_push(de, hs, vs, r, g, b);
      @(posedge pixel_clk);
      #1;
      compare_out();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive_px(1'b0, 1'b1, 1'b1, 8'($urandom), 8'($urandom), 8'($urandom));
   endtask

   task automatic check_reset_vals(input string tag);
      check_val({tag, "_de"},   a_de,   32'd0);
      check_val({tag, "_hs"},   a_hs,   32'd1);
      check_val({tag, "_vs"},   a_vs,   32'd1);
      check_val({tag, "_y"},    a_y,    32'd16);
      check_val({tag, "_cbcr"}, a_cbcr, 32'd128);
      check_val({tag, "_dcbcr"}, d_cbcr, 32'd128);
   endtask

   // asserted asynchronously between edges, with random inputs while held
   task automatic apply_reset(input int ncyc);
      reset_n = 1'b0;
      #1;
      check_reset_vals("rst_async");
      for (int i = 0; i < ncyc; i++) begin
         in_de    = 1'($urandom_range(0, 1));
         in_hsync = 1'($urandom_range(0, 1));
         in_vsync = 1'($urandom_range(0, 1));
         in_r     = 8'($urandom);
         in_g     = 8'($urandom);
         in_b     = 8'($urandom);
         @(posedge pixel_clk);
         #1;
         check_reset_vals("rst_held");
      end
      in_de    = 1'b0;
      in_hsync = 1'b1;
      in_vsync = 1'b1;
      @(negedge pixel_clk);
      reset_n = 1'b1;
      model_reset();
   endtask

   task automatic cap_clear();
      cap_y.delete();
      cap_avg.delete();
      cap_dec.delete();
   endtask

   task automatic check_caps(input string tag);
      check_val({tag, "_count"}, cap_y.size(), ey.size());
      for (int i = 0; i < ey.size(); i++) begin
         check_val($sformatf("%s_y%0d", tag, i),   (i < cap_y.size())   ? cap_y[i]   : -1, ey[i]);
         check_val($sformatf("%s_avg%0d", tag, i), (i < cap_avg.size()) ? cap_avg[i] : -1, ea[i]);
         check_val($sformatf("%s_dec%0d", tag, i), (i < cap_dec.size()) ? cap_dec[i] : -1, ed[i]);
      end
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      #2;
      apply_reset(8);
      idle(3);

      // white, red, green, blue
      cap_clear();
      drive_px(1'b1, 1'b1, 1'b1, 8'd255, 8'd255, 8'd255);
      drive_px(1'b1, 1'b1, 1'b1, 8'd255, 8'd0,   8'd0);
      drive_px(1'b1, 1'b1, 1'b1, 8'd0,   8'd255, 8'd0);
      drive_px(1'b1, 1'b1, 1'b1, 8'd0,   8'd0,   8'd255);
      idle(8);
      ey = '{235, 82, 144, 41};
      ea = '{109, 184, 147, 72};
      ed = '{128, 240, 54, 110};
      check_caps("wrgb");

      // red then blue
      cap_clear();
      drive_px(1'b1, 1'b1, 1'b1, 8'd255, 8'd0, 8'd0);
      drive_px(1'b1, 1'b1, 1'b1, 8'd0,   8'd0, 8'd255);
      idle(8);
      ey = '{82, 41};
      ea = '{165, 175};
      ed = '{90, 110};
      check_caps("rb");

      // 3 black, 1-cycle gap with bright RGB, 2 white
      cap_clear();
      for (int i = 0; i < 3; i++) drive_px(1'b1, 1'b1, 1'b1, 8'd0, 8'd0, 8'd0);
      drive_px(1'b0, 1'b1, 1'b1, 8'd255, 8'd0, 8'd255);
      for (int i = 0; i < 2; i++) drive_px(1'b1, 1'b1, 1'b1, 8'd255, 8'd255, 8'd255);
      idle(8);
      ey = '{16, 16, 16, 235, 235};
      ea = '{128, 128, 128, 128, 128};
      ed = '{128, 128, 128, 128, 128};
      check_caps("gap");

      // odd run, gap, then a run whose Cb differs strongly from the first
      drive_px(1'b1, 1'b1, 1'b1, 8'd0, 8'd255, 8'd0);
      drive_px(1'b0, 1'b1, 1'b1, 8'd0, 8'd0,   8'd255);
      drive_px(1'b1, 1'b1, 1'b1, 8'd0, 8'd0,   8'd255);
      drive_px(1'b1, 1'b1, 1'b1, 8'd255, 8'd0, 8'd0);
      idle(6);

      // scaled raster: 80x12 total, 64x8 active, random RGB everywhere
      for (int ln = 0; ln < 12; ln++) begin
         for (int x = 0; x < 80; x++) begin
            drive_px(1'((ln < 8) && (x < 64)),
                     1'(!((x >= 68) && (x < 72))),
                     1'(!((ln >= 9) && (ln < 11))),
                     8'($urandom), 8'($urandom), 8'($urandom));
         end
      end

      // random DE/sync pattern: odd runs, single-cycle gaps, sync toggling
      for (int i = 0; i < 300; i++) begin
         drive_px(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) != 0),
                  1'($urandom_range(0, 7) != 0), 8'($urandom), 8'($urandom), 8'($urandom));
      end
      idle(6);

      // reset in the middle of an active line, then a fresh line
      for (int i = 0; i < 12; i++) drive_px(1'b1, 1'b1, 1'b1, 8'($urandom), 8'($urandom), 8'($urandom));
      check_val("midline_active", a_de, 32'd1);
      apply_reset(3);
      idle(3);
      cap_clear();
      drive_px(1'b1, 1'b1, 1'b1, 8'd255, 8'd0, 8'd0);
      drive_px(1'b1, 1'b1, 1'b1, 8'd0,   8'd0, 8'd255);
      idle(8);
      ey = '{82, 41};
      ea = '{165, 175};
      ed = '{90, 110};
      check_caps("post_rst");

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
